// File: rtl/seg7_scan_driver.sv
// Multiplexed 8-digit active-low 7-segment driver with shadow/active content registers
// committed only at frame wrap. Optional digit blinking is enabled by defining SEG7_BLINK_EN.
module seg7_scan_driver #(
  parameter int unsigned DIGIT_TICKS = 100000,
  parameter int unsigned BLINK_TICKS = 50000000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] DISP_DATA,
  input  logic [7:0]  DISP_EN,
  input  logic [7:0]  DISP_DP,
  input  logic [7:0]  BLINK_MASK,
  input  logic        LOAD,
  output logic        LOAD_ACK,
  output logic        PENDING,
  output logic        SCAN_TICK,
  output logic [7:0]  AN,
  output logic [7:0]  SEG
);

  localparam int unsigned PW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIGIT_TICKS - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic [2:0]    idx_q, idx_d;
  logic          pending_q, pending_d;
  logic          commit;

  logic [31:0] sh_data_q, sh_data_d, act_data_q, act_data_d;
  logic [7:0]  sh_en_q, sh_en_d, act_en_q, act_en_d;
  logic [7:0]  sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic [7:0]  sh_mask_q, sh_mask_d, act_mask_q, act_mask_d;

  logic [7:0] an_q, an_d;
  logic [7:0] seg_q, seg_d;
  logic       phase_d;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // tick_q is a registered look-ahead of the terminal count, so it is low in reset
  // even when DIGIT_TICKS is 1.
  always_comb begin
    presc_d = (tick_q || (presc_q == PRESC_LAST)) ? '0 : presc_q + 1'b1;
    tick_d  = (presc_d == PRESC_LAST);
    idx_d   = tick_q ? idx_q + 3'd1 : idx_q;
  end

  // A LOAD on the wrap tick itself commits straight from the inputs.
  assign commit = tick_q && (idx_q == 3'd7) && (pending_q || LOAD);

  always_comb begin
    sh_data_d  = sh_data_q;
    sh_en_d    = sh_en_q;
    sh_dp_d    = sh_dp_q;
    sh_mask_d  = sh_mask_q;
    act_data_d = act_data_q;
    act_en_d   = act_en_q;
    act_dp_d   = act_dp_q;
    act_mask_d = act_mask_q;
    pending_d  = pending_q;
    if (LOAD) begin
      sh_data_d = DISP_DATA;
      sh_en_d   = DISP_EN;
      sh_dp_d   = DISP_DP;
      sh_mask_d = BLINK_MASK;
      pending_d = 1'b1;
    end
    if (commit) begin
      act_data_d = LOAD ? DISP_DATA  : sh_data_q;
      act_en_d   = LOAD ? DISP_EN    : sh_en_q;
      act_dp_d   = LOAD ? DISP_DP    : sh_dp_q;
      act_mask_d = LOAD ? BLINK_MASK : sh_mask_q;
      pending_d  = 1'b0;
    end
  end

`ifdef SEG7_BLINK_EN
  localparam int unsigned BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q;

  always_comb begin
    blink_cnt_d = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + 1'b1;
    phase_d     = (blink_cnt_q == BLINK_LAST) ? ~phase_q : phase_q;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end
`else
  assign phase_d = 1'b0;
`endif

  // Output registers are built from next-state values so a commit shows on digit 0 next cycle.
  always_comb begin
    if (act_en_d[idx_d] && !(phase_d && act_mask_d[idx_d])) begin
      an_d = ~(8'd1 << idx_d);
    end else begin
      an_d = 8'hFF;
    end
    seg_d = {~act_dp_d[idx_d], seg_decode(act_data_d[{idx_d, 2'b00} +: 4])};
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      presc_q    <= '0;
      tick_q     <= 1'b0;
      idx_q      <= 3'd0;
      pending_q  <= 1'b0;
      sh_data_q  <= '0;
      sh_en_q    <= '0;
      sh_dp_q    <= '0;
      sh_mask_q  <= '0;
      act_data_q <= '0;
      act_en_q   <= '0;
      act_dp_q   <= '0;
      act_mask_q <= '0;
      an_q       <= 8'hFF;
      seg_q      <= 8'hFF;
    end else begin
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      idx_q      <= idx_d;
      pending_q  <= pending_d;
      sh_data_q  <= sh_data_d;
      sh_en_q    <= sh_en_d;
      sh_dp_q    <= sh_dp_d;
      sh_mask_q  <= sh_mask_d;
      act_data_q <= act_data_d;
      act_en_q   <= act_en_d;
      act_dp_q   <= act_dp_d;
      act_mask_q <= act_mask_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign SCAN_TICK = tick_q;
  assign LOAD_ACK  = commit;
  assign PENDING   = pending_q;
  assign AN        = an_q;
  assign SEG       = seg_q;

endmodule
